clk_divider_multi: RTL and testbench
====================================

CLK_DIVIDER_MULTI -- requirements
Module: clk_divider_multi

Interface
REQ-001 Parameter NCH, default 4: number of independent divider channels, range 1..16.
REQ-002 Parameter WIDTH, default 16: counter and divisor width in bits.
REQ-003 Parameter RESET_DIV, default 0: divisor value loaded into every channel at reset.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 en  in  NCH  per-channel run enable.
REQ-007 mode  in  NCH  per-channel mode: 0 = toggle (square clock), 1 = pulse (one-cycle tick).
REQ-008 wr_en  in  1  divisor write strobe.
REQ-009 wr_ch  in  $clog2(NCH) (min 1)  target channel of the write.
REQ-010 wr_div  in  WIDTH  divisor value to write.
REQ-011 out_clk  out  NCH  divided clock, one per channel, registered.
REQ-012 out_clk_n  out  NCH  bitwise inverse of out_clk, combinational.
REQ-013 tick  out  NCH  one-cycle pulse at each terminal count, registered.
REQ-014 busy  out  NCH  high while a written divisor is pending and not yet active.

Function
REQ-015 Each channel SHALL hold counter cnt, active divisor act, pending divisor pend and pending flag pf, all WIDTH bits except pf.
REQ-016 With en[i]=1, cnt SHALL increment by 1 each cycle; the terminal count is cnt==act, at which point cnt SHALL load 0 instead.
REQ-017 At terminal count in toggle mode, out_clk[i] SHALL invert; the half-period is therefore act+1 cycles and the full period 2*(act+1) cycles.
REQ-018 At terminal count in pulse mode, tick[i] SHALL be 1 for exactly the next cycle, and out_clk[i] SHALL hold 0.
REQ-019 tick[i] SHALL also pulse at terminal count in toggle mode, so it marks every edge of out_clk.
REQ-020 act=0 SHALL give out_clk = clk/2 in toggle mode and tick continuously high in pulse mode.
REQ-021 With en[i]=0, cnt, out_clk[i] and tick[i] SHALL be 0 on the next edge, and act SHALL take pend immediately if pf=1, clearing pf.
REQ-022 A write (wr_en=1) SHALL store wr_div into pend of channel wr_ch and set pf; wr_ch >= NCH SHALL be ignored.
REQ-023 A pending divisor SHALL become active only at terminal count (pf cleared, act<=pend), so no out_clk phase is shortened or glitched.
REQ-024 A write coinciding with terminal count of the same channel SHALL load wr_div directly into act, leaving pf=0.
REQ-025 A second write before activation SHALL overwrite pend; only the last value takes effect.
REQ-026 busy[i] SHALL equal pf of channel i.
REQ-027 A mode change while running SHALL take effect at the next terminal count; out_clk[i] SHALL be forced to 0 when entering pulse mode.
REQ-028 Counter arithmetic SHALL be modulo 2^WIDTH and cannot overflow, since cnt never exceeds act.

Reset
REQ-029 On rst=1, every channel SHALL set cnt=0, act=pend=RESET_DIV, pf=0, out_clk=0 and tick=0 on the next edge.
REQ-030 rst SHALL take priority over en, wr_en and terminal count.
REQ-031 Reset mid-period SHALL discard partial counts and pending writes.

Structure
REQ-032 Package clkdiv_pkg SHALL hold the mode encoding constants (MODE_TOGGLE=0, MODE_PULSE=1) and the default WIDTH.
REQ-033 One channel SHALL be a sub-module, clkdiv_channel, instantiated NCH times by a generate loop.
REQ-034 The top level SHALL contain only write decode and output concatenation.

Verification
REQ-035 After reset with RESET_DIV=0, toggle, en=1: out_clk toggles every cycle; tick is constantly high after the first edge.
REQ-036 Write div=3 to channel 1 in toggle mode: out_clk period is 8 cycles (4 high, 4 low); busy[1] is high until the first terminal count.
REQ-037 Pulse mode with div=4: tick is high 1 of every 5 cycles and out_clk stays 0.
REQ-038 Write div=9 mid-period while running at div=2: the current half-period completes at 3 cycles, and subsequent half-periods are 10 cycles.
REQ-039 Drop en mid-period, then reassert it: outputs are 0 on the next edge, and counting restarts from cnt=0 with the pending divisor applied.
REQ-040 Assert rst while channels run with pending writes: all outputs are 0, busy is 0 and act=RESET_DIV; wr_ch=NCH is ignored.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared constants for the multi-channel clock divider.
package clkdiv_pkg;
  localparam int DEF_WIDTH = 16;

  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;
endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, active/pending divisor, toggle or pulse output.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int RESET_DIV = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             wr_hit,
  input  logic [WIDTH-1:0] wr_div,
  output logic             out_clk,
  output logic             tick,
  output logic             busy
);
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] act_q, act_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pf_q, pf_d;
  logic             out_q, out_d;
  logic             tick_q, tick_d;
  logic             tc;

  // cnt never exceeds act, so the equality compare is the whole terminal test
  assign tc = (cnt_q == act_q);

  // Next-state: count, swap in pending divisor only at a phase boundary
  always_comb begin
    cnt_d  = cnt_q;
    act_d  = act_q;
    pend_d = pend_q;
    pf_d   = pf_q;
    out_d  = out_q;
    tick_d = 1'b0;
    if (!en) begin
      // Idle channel: no phase to protect, so a pending divisor lands now
      cnt_d = '0;
      out_d = 1'b0;
      if (pf_q) begin
        act_d = pend_q;
        pf_d  = 1'b0;
      end
      if (wr_hit) begin
        pend_d = wr_div;
        pf_d   = 1'b1;
      end
    end else if (tc) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      out_d  = (mode == MODE_TOGGLE) ? ~out_q : 1'b0;
      if (wr_hit) begin
        // Write on the boundary itself bypasses the pending slot
        act_d  = wr_div;
        pend_d = wr_div;
        pf_d   = 1'b0;
      end else if (pf_q) begin
        act_d = pend_q;
        pf_d  = 1'b0;
      end
    end else begin
      cnt_d = cnt_q + WIDTH'(1);
      if (wr_hit) begin
        pend_d = wr_div;
        pf_d   = 1'b1;
      end
    end
  end

  // State register with synchronous reset taking priority over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      act_q  <= WIDTH'(RESET_DIV);
      pend_q <= WIDTH'(RESET_DIV);
      pf_q   <= 1'b0;
      out_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      pend_q <= pend_d;
      pf_q   <= pf_d;
      out_q  <= out_d;
      tick_q <= tick_d;
    end
  end

  assign out_clk = out_q;
  assign tick    = tick_q;
  assign busy    = pf_q;
endmodule

// File: rtl/clk_divider_multi.sv
// Multi-channel programmable clock divider: write decode plus channel array.
module clk_divider_multi
  import clkdiv_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int RESET_DIV = 0,
  localparam int CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   en,
  input  logic [NCH-1:0]   mode,
  input  logic             wr_en,
  input  logic [CHW-1:0]   wr_ch,
  input  logic [WIDTH-1:0] wr_div,
  output logic [NCH-1:0]   out_clk,
  output logic [NCH-1:0]   out_clk_n,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   busy
);
  logic [NCH-1:0] wr_hit;

  // Out-of-range channel numbers match no instance and are dropped
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign wr_hit[i] = wr_en && (wr_ch == CHW'(i));

    clkdiv_channel #(
      .WIDTH    (WIDTH),
      .RESET_DIV(RESET_DIV)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .en     (en[i]),
      .mode   (mode[i]),
      .wr_hit (wr_hit[i]),
      .wr_div (wr_div),
      .out_clk(out_clk[i]),
      .tick   (tick[i]),
      .busy   (busy[i])
    );
  end

  assign out_clk_n = ~out_clk;
endmodule

// File: tb/tb_clk_divider_multi.sv
// Scoreboard bench: stimulus queues per-edge expectations, monitor checks them.
module tb_clk_divider_multi;
  localparam int NCH = 3;
  localparam int W   = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] en, mode;
  logic           wr_en;
  logic [1:0]     wr_ch;
  logic [W-1:0]   wr_div;
  logic [NCH-1:0] out_clk, out_clk_n, tick, busy;

  clk_divider_multi #(.NCH(NCH), .WIDTH(W), .RESET_DIV(0)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .wr_en(wr_en),
    .wr_ch(wr_ch), .wr_div(wr_div), .out_clk(out_clk),
    .out_clk_n(out_clk_n), .tick(tick), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int             due;
    string          name;
    logic [NCH-1:0] m, eo, et, eb;
  } exp_t;
  exp_t q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string nm, string fld, logic [NCH-1:0] got, logic [NCH-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s %s: got %b want %b (cycle %0d)", nm, fld, got, want, cyc);
    end
  endtask

  // Monitor: check every expectation due at this edge
  initial begin
    forever begin
      @(posedge clk);
      #2;
      while (q.size() > 0 && q[0].due <= cyc) begin
        exp_t e;
        e = q.pop_front();
        if (e.due < cyc) begin
          n_cmp++;
          n_bad++;
          $display("FAIL %s missed: got cycle %0d want %0d", e.name, cyc, e.due);
        end else begin
          chk(e.name, "out_clk",   out_clk   & e.m, e.eo & e.m);
          chk(e.name, "out_clk_n", out_clk_n & e.m, ~e.eo & e.m);
          chk(e.name, "tick",      tick      & e.m, e.et & e.m);
          chk(e.name, "busy",      busy      & e.m, e.eb & e.m);
        end
      end
    end
  end

  // Queue the outputs expected after the coming edge, then cross it
  task automatic step(string nm, logic [NCH-1:0] m, logic [NCH-1:0] eo,
                      logic [NCH-1:0] et, logic [NCH-1:0] eb);
    exp_t e;
    e.due = cyc + 1; e.name = nm; e.m = m; e.eo = eo; e.et = et; e.eb = eb;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(string nm);
    rst = 1'b1; en = '0; mode = '0; wr_en = 1'b0;
    step(nm, 3'b111, 3'b000, 3'b000, 3'b000);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = '0; mode = '0; wr_en = 1'b0; wr_ch = '0; wr_div = '0;
    @(posedge clk);
    #1;

    // Reset state, then divisor 0 toggles every cycle with tick always high
    do_reset("reset");
    en = 3'b001;
    for (int k = 0; k < 6; k++)
      step($sformatf("div0_%0d", k), 3'b001, (k % 2 == 0) ? 3'b001 : 3'b000, 3'b001, 3'b000);

    // Write div=3 to ch1 coinciding with its terminal count: direct load, period 8
    do_reset("rst2");
    en = 3'b010; wr_en = 1'b1; wr_ch = 2'd1; wr_div = 8'd3;
    step("wr_at_tc", 3'b010, 3'b010, 3'b010, 3'b000);
    wr_en = 1'b0;
    for (int k = 1; k <= 16; k++)
      step($sformatf("div3_%0d", k), 3'b010, ((k / 4) % 2 == 0) ? 3'b010 : 3'b000,
           (k % 4 == 0) ? 3'b010 : 3'b000, 3'b000);

    // Pulse mode div=4 on ch2, then overwrite a pending divisor twice (7 then 1)
    do_reset("rst3");
    en = 3'b100; mode = 3'b100; wr_en = 1'b1; wr_ch = 2'd2; wr_div = 8'd4;
    step("pulse_wr", 3'b100, 3'b000, 3'b100, 3'b000);
    wr_en = 1'b0;
    for (int k = 1; k <= 15; k++)
      step($sformatf("pulse4_%0d", k), 3'b100, 3'b000, (k % 5 == 0) ? 3'b100 : 3'b000, 3'b000);
    wr_en = 1'b1; wr_div = 8'd7;
    step("pend_a", 3'b100, 3'b000, 3'b000, 3'b100);
    wr_div = 8'd1;
    step("pend_b", 3'b100, 3'b000, 3'b000, 3'b100);
    wr_en = 1'b0;
    for (int k = 18; k <= 24; k++)
      step($sformatf("pulse1_%0d", k), 3'b100, 3'b000,
           (k >= 20 && k % 2 == 0) ? 3'b100 : 3'b000, (k < 20) ? 3'b100 : 3'b000);

    // Toggle at div=2 on ch1, div=9 written mid-period takes over at the boundary
    do_reset("rst4");
    en = 3'b010; wr_en = 1'b1; wr_ch = 2'd1; wr_div = 8'd2;
    step("d2_0", 3'b010, 3'b010, 3'b010, 3'b000);
    wr_en = 1'b0;
    step("d2_1", 3'b010, 3'b010, 3'b000, 3'b000);
    step("d2_2", 3'b010, 3'b010, 3'b000, 3'b000);
    step("d2_3", 3'b010, 3'b000, 3'b010, 3'b000);
    wr_en = 1'b1; wr_div = 8'd9;
    step("d9_wr", 3'b010, 3'b000, 3'b000, 3'b010);
    wr_en = 1'b0;
    step("d9_pend", 3'b010, 3'b000, 3'b000, 3'b010);
    for (int k = 6; k <= 30; k++) begin
      int j;
      j = k - 6;
      step($sformatf("d9_%0d", k), 3'b010, ((j / 10) % 2 == 0) ? 3'b010 : 3'b000,
           (j % 10 == 0) ? 3'b010 : 3'b000, 3'b000);
    end

    // Drop en with a pending divisor: outputs clear, divisor 1 applied on restart
    wr_en = 1'b1; wr_div = 8'd1;
    step("en_pend", 3'b010, 3'b010, 3'b000, 3'b010);
    wr_en = 1'b0; en = 3'b000;
    step("en_off0", 3'b010, 3'b000, 3'b000, 3'b000);
    step("en_off1", 3'b010, 3'b000, 3'b000, 3'b000);
    en = 3'b010;
    step("en_on0", 3'b010, 3'b000, 3'b000, 3'b000);
    step("en_on1", 3'b010, 3'b010, 3'b010, 3'b000);
    step("en_on2", 3'b010, 3'b010, 3'b000, 3'b000);
    step("en_on3", 3'b010, 3'b000, 3'b010, 3'b000);

    // Reset over running channels with pending and concurrent writes
    wr_en = 1'b1; wr_div = 8'd5;
    step("pre_rst", 3'b010, 3'b000, 3'b000, 3'b010);
    rst = 1'b1; en = 3'b011; wr_div = 8'd6;
    step("rst_prio", 3'b111, 3'b000, 3'b000, 3'b000);
    rst = 1'b0; wr_ch = 2'd3; wr_div = 8'd9;
    step("oor_0", 3'b111, 3'b011, 3'b011, 3'b000);
    wr_en = 1'b0;
    for (int k = 1; k <= 5; k++)
      step($sformatf("oor_%0d", k), 3'b111, (k % 2 == 0) ? 3'b011 : 3'b000, 3'b011, 3'b000);

    // Drain: bounded wait for the monitor to consume all expectations
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    #3;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
